// File: rtl/unary_acc_pkg.sv
// Shared types and constants for the unary-rate accumulator array.
// Saturating arithmetic is enabled by defining UNARY_ACC_SAT_EN.
package unary_acc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int STEP  = 1;
   localparam int MAX_W = 64;

   // Low w bits hold the two's complement extreme; callers truncate to w.
   function automatic logic [MAX_W-1:0] signed_max(input int w);
      return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
   endfunction

   function automatic logic [MAX_W-1:0] signed_min(input int w);
      return ~signed_max(w);
   endfunction

endpackage

// File: rtl/unary_acc_lane.sv
// One accumulator lane: signed +/-1 step per product bit, optional upstream fold,
// and (with UNARY_ACC_SAT_EN) clamping at the signed limits plus a sticky flag.
module unary_acc_lane
   import unary_acc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             i_clear,
   input  logic             i_step,
   input  logic             i_first,
   input  logic             i_acc,
   input  logic             i_sign_i,
   input  logic             i_sign_w,
   input  logic             i_prod,
   input  logic [WIDTH-1:0] i_psum,
   output logic [WIDTH-1:0] o_psum,
   output logic             o_sat
);

   localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

   logic [WIDTH-1:0] r_lane;
   logic [WIDTH-1:0] w_base;
   logic [WIDTH-1:0] w_next;
   logic             w_up;
   logic             w_dn;
   logic             w_clamp;

   assign w_base = (i_first && i_acc) ? i_psum : r_lane;
   assign w_up   = i_prod && !(i_sign_i ^ i_sign_w);
   assign w_dn   = i_prod && (i_sign_i ^ i_sign_w);

`ifdef UNARY_ACC_SAT_EN
   localparam logic [WIDTH-1:0] LANE_MAX = WIDTH'(signed_max(WIDTH));
   localparam logic [WIDTH-1:0] LANE_MIN = WIDTH'(signed_min(WIDTH));
   logic r_sat;

   // The clamp looks at base, so a fold alone can never trip it.
   assign w_clamp = (w_up && (w_base == LANE_MAX)) || (w_dn && (w_base == LANE_MIN));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sat <= 1'b0;
      end else if (clr || i_clear) begin
         r_sat <= 1'b0;
      end else if (i_step && w_clamp) begin
         r_sat <= 1'b1;
      end
   end

   assign o_sat = r_sat;
`else
   assign w_clamp = 1'b0;
   assign o_sat   = 1'b0;
`endif

   always_comb begin
      w_next = w_base;
      if (!w_clamp) begin
         if (w_up) begin
            w_next = w_base + STEP_V;
         end else if (w_dn) begin
            w_next = w_base - STEP_V;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lane <= '0;
      end else if (clr || i_clear) begin
         r_lane <= '0;
      end else if (i_step) begin
         r_lane <= w_next;
      end
   end

   assign o_psum = r_lane;

endmodule

// File: rtl/unary_acc_array.sv
// Multi-lane unary-rate partial-sum accumulator with a stallable result drain.
// Saturating lanes are built when UNARY_ACC_SAT_EN is defined; otherwise lanes wrap.
module unary_acc_array
   import unary_acc_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int WIDTH  = 32,
   parameter int CYCLES = 256,
   parameter int CNT_W  = $clog2(CYCLES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   start,
   input  logic                   en,
   input  logic                   acc,
   input  logic [LANES-1:0]       sign_i,
   input  logic [LANES-1:0]       sign_w,
   input  logic [LANES-1:0]       prod_bit,
   input  logic [LANES*WIDTH-1:0] psum_i,
   output logic [LANES*WIDTH-1:0] psum_o,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic                   busy,
   output logic [LANES-1:0]       sat,
   output logic [1:0]             o_dbg_state
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_valid;
   logic             r_busy;
   logic             w_win_start;
   logic             w_step;
   logic             w_first;

   // Result handshake: o_valid stays high in DONE with psum_o/sat frozen; the
   // result is consumed on a cycle where o_valid && o_ready, and only then may
   // a new start be taken from DONE.
   assign w_win_start = start && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && o_ready));
   assign w_step      = (r_state == ST_RUN) && en;
   assign w_first     = (r_cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else if (clr) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_RUN;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (en) begin
                  if (r_cnt == CNT_LAST) begin
                     r_state <= ST_DONE;
                     r_cnt   <= '0;
                     r_valid <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            ST_DONE: begin
               if (o_ready) begin
                  r_valid <= 1'b0;
                  r_cnt   <= '0;
                  if (start) begin
                     r_state <= ST_RUN;
                     r_busy  <= 1'b1;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_valid     = r_valid;
   assign busy        = r_busy;
   assign o_dbg_state = r_state;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      unary_acc_lane #(
         .WIDTH (WIDTH)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .clr      (clr),
         .i_clear  (w_win_start),
         .i_step   (w_step),
         .i_first  (w_first),
         .i_acc    (acc),
         .i_sign_i (sign_i[k]),
         .i_sign_w (sign_w[k]),
         .i_prod   (prod_bit[k]),
         .i_psum   (psum_i[k*WIDTH +: WIDTH]),
         .o_psum   (psum_o[k*WIDTH +: WIDTH]),
         .o_sat    (sat[k])
      );
   end

endmodule

// File: tb/tb_unary_acc_array.sv
// Directed bench for unary_acc_array (LANES=4, WIDTH=8, CYCLES=4).
// Saturation expectations follow UNARY_ACC_SAT_EN as defined for the build.
module tb_unary_acc_array;
   import unary_acc_pkg::*;

   localparam int LANES  = 4;
   localparam int WIDTH  = 8;
   localparam int CYCLES = 4;

   logic                   clk;
   logic                   rst;
   logic                   clr;
   logic                   start;
   logic                   en;
   logic                   acc;
   logic [LANES-1:0]       sign_i;
   logic [LANES-1:0]       sign_w;
   logic [LANES-1:0]       prod_bit;
   logic [LANES*WIDTH-1:0] psum_i;
   logic [LANES*WIDTH-1:0] psum_o;
   logic                   o_valid;
   logic                   o_ready;
   logic                   busy;
   logic [LANES-1:0]       sat;
   logic [1:0]             dbg_state;

   int n_vec;
   int n_err;
   logic [WIDTH-1:0] exp_q[$];

   unary_acc_array #(
      .LANES  (LANES),
      .WIDTH  (WIDTH),
      .CYCLES (CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .start       (start),
      .en          (en),
      .acc         (acc),
      .sign_i      (sign_i),
      .sign_w      (sign_w),
      .prod_bit    (prod_bit),
      .psum_i      (psum_i),
      .psum_o      (psum_o),
      .o_valid     (o_valid),
      .o_ready     (o_ready),
      .busy        (busy),
      .sat         (sat),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      clr = 0; start = 0; en = 0; acc = 0; o_ready = 0;
      sign_i = '0; sign_w = '0; prod_bit = '0; psum_i = '0;
   endtask

   function automatic logic [WIDTH-1:0] lane(input int k);
      return psum_o[k*WIDTH +: WIDTH];
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      drive_idle();
      rst = 1;
      #2;
      n_vec++; if (psum_o !== 32'h0) begin n_err++; $display("FAIL reset_psum: got %h exp %h", psum_o, 32'h0); end
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", o_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
      n_vec++; if (sat !== 4'h0) begin n_err++; $display("FAIL reset_sat: got %h exp 0", sat); end
      n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE); end
      tick();
      tick();
      rst = 0;
      tick();
   endtask

   task automatic test_basic();
      start = 1;
      tick();
      start = 0;
      n_vec++; if (dbg_state !== ST_RUN) begin n_err++; $display("FAIL basic_run_state: got %0d exp %0d", dbg_state, ST_RUN); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b exp 1", busy); end
      en = 1; prod_bit = 4'hF;
      repeat (3) tick();
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b exp 0", o_valid); end
      n_vec++; if (lane(0) !== 8'd3) begin n_err++; $display("FAIL basic_partial: got %0d exp 3", lane(0)); end
      tick();
      en = 0; prod_bit = '0;
      n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b exp 1", o_valid); end
      n_vec++; if (dbg_state !== ST_DONE) begin n_err++; $display("FAIL basic_done_state: got %0d exp %0d", dbg_state, ST_DONE); end
      n_vec++; if (psum_o !== 32'h04040404) begin n_err++; $display("FAIL basic_psum: got %h exp %h", psum_o, 32'h04040404); end
      o_ready = 1;
      tick();
      o_ready = 0;
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL basic_release_valid: got %b exp 0", o_valid); end
      n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL basic_idle: got %0d exp %0d", dbg_state, ST_IDLE); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy: got %b exp 0", busy); end
      n_vec++; if (psum_o !== 32'h04040404) begin n_err++; $display("FAIL basic_keep: got %h exp %h", psum_o, 32'h04040404); end
   endtask

   task automatic test_fold();
      logic [3:0] pat [4];
      logic [3:0] sw_cfg [2];
      logic [7:0] exp_v [2];
      pat[0] = 4'hF; pat[1] = 4'h0; pat[2] = 4'hF; pat[3] = 4'hF;
      sw_cfg[0] = 4'h0; sw_cfg[1] = 4'hF;
      exp_v[0] = 8'd97; exp_v[1] = 8'd103;
      for (int r = 0; r < 2; r++) begin
         start = 1;
         tick();
         start = 0;
         acc = 1; psum_i = {4{8'd100}}; sign_i = 4'hF; sign_w = sw_cfg[r]; en = 1;
         for (int c = 0; c < 4; c++) begin
            prod_bit = pat[c];
            tick();
         end
         en = 0; acc = 0; prod_bit = '0;
         n_vec++; if (psum_o !== {4{exp_v[r]}}) begin n_err++; $display("FAIL fold_%0d: got %h exp %h", r, psum_o, {4{exp_v[r]}}); end
         n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL fold_valid_%0d: got %b exp 1", r, o_valid); end
         o_ready = 1;
         tick();
         o_ready = 0;
      end
      sign_i = '0; sign_w = '0; psum_i = '0;
   endtask

   task automatic test_stall();
      start = 1;
      tick();
      start = 0;
      en = 1; prod_bit = 4'hF;
      tick();
      tick();
      en = 0; start = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if (psum_o !== 32'h02020202) begin n_err++; $display("FAIL stall_hold_%0d: got %h exp %h", i, psum_o, 32'h02020202); end
         n_vec++; if (dbg_state !== ST_RUN) begin n_err++; $display("FAIL stall_state_%0d: got %0d exp %0d", i, dbg_state, ST_RUN); end
      end
      start = 0; en = 1;
      tick();
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL stall_cnt_held: got %b exp 0", o_valid); end
      tick();
      en = 0; prod_bit = '0;
      n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b exp 1", o_valid); end
      start = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid_%0d: got %b exp 1", i, o_valid); end
         n_vec++; if (psum_o !== 32'h04040404) begin n_err++; $display("FAIL drain_psum_%0d: got %h exp %h", i, psum_o, 32'h04040404); end
         n_vec++; if (dbg_state !== ST_DONE) begin n_err++; $display("FAIL drain_state_%0d: got %0d exp %0d", i, dbg_state, ST_DONE); end
      end
      start = 0;
   endtask

   task automatic test_back_to_back();
      o_ready = 1; start = 1;
      tick();
      o_ready = 0; start = 0;
      n_vec++; if (dbg_state !== ST_RUN) begin n_err++; $display("FAIL b2b_state: got %0d exp %0d", dbg_state, ST_RUN); end
      n_vec++; if (psum_o !== 32'h0) begin n_err++; $display("FAIL b2b_cleared: got %h exp 0", psum_o); end
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid: got %b exp 0", o_valid); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b exp 1", busy); end
      acc = 1; psum_i = 32'h11223344; prod_bit = '0; en = 1;
      tick();
      acc = 0; psum_i = 32'h55667788;
      n_vec++; if (psum_o !== 32'h11223344) begin n_err++; $display("FAIL fold_load: got %h exp %h", psum_o, 32'h11223344); end
      repeat (3) tick();
      en = 0;
      n_vec++; if (psum_o !== 32'h11223344) begin n_err++; $display("FAIL fold_only: got %h exp %h", psum_o, 32'h11223344); end
      n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL fold_only_valid: got %b exp 1", o_valid); end
      o_ready = 1;
      tick();
      o_ready = 0; psum_i = '0;
   endtask

   task automatic test_sat();
      logic [31:0] exp_psum;
      logic [3:0]  exp_sat;
`ifdef UNARY_ACC_SAT_EN
      exp_psum = 32'h0404807F;
      exp_sat  = 4'b0011;
`else
      exp_psum = 32'h04047D82;
      exp_sat  = 4'b0000;
`endif
      start = 1;
      tick();
      start = 0;
      acc = 1; psum_i = {8'h00, 8'h00, 8'h81, 8'h7E}; sign_i = 4'b0010; sign_w = '0;
      prod_bit = 4'hF; en = 1;
      repeat (4) tick();
      en = 0; acc = 0; prod_bit = '0; sign_i = '0; psum_i = '0;
      n_vec++; if (psum_o !== exp_psum) begin n_err++; $display("FAIL sat_psum: got %h exp %h", psum_o, exp_psum); end
      n_vec++; if (sat !== exp_sat) begin n_err++; $display("FAIL sat_flag: got %b exp %b", sat, exp_sat); end
      o_ready = 1; start = 1;
      tick();
      o_ready = 0; start = 0;
      n_vec++; if (sat !== 4'b0000) begin n_err++; $display("FAIL sat_clear_on_start: got %b exp 0000", sat); end
   endtask

   task automatic test_clear();
      en = 1; prod_bit = 4'hF;
      tick();
      n_vec++; if (psum_o !== 32'h01010101) begin n_err++; $display("FAIL clr_pre: got %h exp %h", psum_o, 32'h01010101); end
      clr = 1; start = 1; o_ready = 1;
      tick();
      clr = 0; start = 0; o_ready = 0; en = 0; prod_bit = '0;
      n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL clr_state: got %0d exp %0d", dbg_state, ST_IDLE); end
      n_vec++; if (psum_o !== 32'h0) begin n_err++; $display("FAIL clr_psum: got %h exp 0", psum_o); end
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid: got %b exp 0", o_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL clr_busy: got %b exp 0", busy); end
      tick();
      n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL clr_stay_idle: got %0d exp %0d", dbg_state, ST_IDLE); end
   endtask

   task automatic test_async_reset();
      start = 1;
      tick();
      start = 0; en = 1; prod_bit = 4'hF;
      repeat (4) tick();
      en = 0; prod_bit = '0;
      n_vec++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid: got %b exp 1", o_valid); end
      #3;
      rst = 1;
      #1;
      n_vec++; if (psum_o !== 32'h0) begin n_err++; $display("FAIL arst_psum: got %h exp 0", psum_o); end
      n_vec++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b exp 0", o_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b exp 0", busy); end
      n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL arst_state: got %0d exp %0d", dbg_state, ST_IDLE); end
      #1;
      rst = 0;
      tick();
   endtask

   task automatic test_lanes();
      logic [3:0]       pat [4];
      logic [WIDTH-1:0] fold [4];
      logic [WIDTH-1:0] v;
      logic [WIDTH-1:0] got;
      logic [3:0]       si;
      logic [3:0]       sw;
      logic [31:0]      exp_packed;
      pat[0] = 4'hF; pat[1] = 4'hA; pat[2] = 4'h6; pat[3] = 4'hD;
      fold[0] = 8'd10; fold[1] = 8'hFB; fold[2] = 8'd20; fold[3] = 8'd0;
      si = 4'b0101; sw = 4'b0011;
      exp_packed = '0;
      for (int k = 0; k < LANES; k++) begin
         v = fold[k];
         for (int c = 0; c < CYCLES; c++) begin
            if (pat[c][k]) v = (si[k] ^ sw[k]) ? v - 8'd1 : v + 8'd1;
         end
         exp_q.push_back(v);
         exp_packed[k*WIDTH +: WIDTH] = v;
      end
      start = 1;
      tick();
      start = 0;
      sign_i = si; sign_w = sw; acc = 1;
      psum_i = {fold[3], fold[2], fold[1], fold[0]};
      en = 1;
      for (int c = 0; c < CYCLES; c++) begin
         prod_bit = pat[c];
         tick();
      end
      en = 0; acc = 0; prod_bit = '0;
      for (int k = 0; k < LANES; k++) begin
         v = exp_q.pop_front();
         got = lane(k);
         n_vec++; if (got !== v) begin n_err++; $display("FAIL lane_%0d: got %h exp %h", k, got, v); end
      end
      n_vec++; if (psum_o !== exp_packed) begin n_err++; $display("FAIL lane_packing: got %h exp %h", psum_o, exp_packed); end
      o_ready = 1;
      tick();
      o_ready = 0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_fold();
      test_stall();
      test_back_to_back();
      test_sat();
      test_clear();
      test_async_reset();
      test_lanes();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
